ternary_mac_out: RTL
====================

TERNARY_MAC_OUT -- requirements
Module: ternary_mac_out

Interface
REQ-001 SHALL have parameter MAX_IN_LEN, default 16, maximum activations per output channel.
REQ-002 SHALL have parameter MAX_OUT_LEN, default 8, maximum output channels.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ena  input  1  run request; held high by controller until uo_done.
REQ-006 SHALL have port ui_param  input  7  [6:3]=in_len-1, [2:0]=out_len-1.
REQ-007 SHALL have port ui_weights  input  2*MAX_IN_LEN*MAX_OUT_LEN  packed ternary weights; weight(i,o) at bits [2*(o*MAX_IN_LEN+i) +: 2].
REQ-008 SHALL have port ui_input  input  16  two signed int8 activations per beat: [15:8]=x[2k], [7:0]=x[2k+1].
REQ-009 SHALL have port in_valid  input  1  ui_input beat qualifier.
REQ-010 SHALL have port uo_output  output  8  result byte stream.
REQ-011 SHALL have port out_valid  output  1  uo_output qualifier.
REQ-012 SHALL have port uo_done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL decode weights: 2'b01=+1, 2'b11=-1, 2'b00 and 2'b10=0.
REQ-014 SHALL implement FSM IDLE -> ACCUM -> DRAIN -> DONE -> IDLE.
REQ-015 IDLE: on ena=1, SHALL latch in_len/out_len from ui_param, clear all accumulators, enter ACCUM next cycle.
REQ-016 ACCUM: each cycle with in_valid=1, SHALL add w(2k,o)*x[2k] + w(2k+1,o)*x[2k+1] into every accumulator o < out_len in parallel; in_valid=0 cycles SHALL hold state.
REQ-017 ACCUM SHALL consume ceil(in_len/2) beats; for odd in_len, ui_input[7:0] of the final beat SHALL be ignored; after the final beat SHALL enter DRAIN.
REQ-018 Accumulators SHALL be 16-bit signed (range of 16 x int8 fits; no overflow possible).
REQ-019 DRAIN SHALL emit channels 0..out_len-1 in order, one byte per cycle, out_valid=1, no gaps, no backpressure; channels >= out_len SHALL NOT be emitted.
REQ-020 DONE SHALL assert uo_done=1 for exactly one cycle with out_valid=0, then return to IDLE.
REQ-021 Back-to-back runs: ena still high in IDLE after DONE SHALL start a new run (controller lowers ena on uo_done).
REQ-022 ena=0 in ACCUM or DRAIN SHALL abort to IDLE next cycle; no uo_done pulse; partial results discarded.
REQ-023 Outside DRAIN, uo_output SHALL be 8'h00 and out_valid 0.
REQ-024 ui_weights SHALL be sampled live; it SHALL remain stable from ena rise to uo_done (controller guarantee).

Reset
REQ-025 rst=1 SHALL force IDLE, clear accumulators, beat and channel counters, latched config; uo_output=8'h00, out_valid=0, uo_done=0.
REQ-026 rst mid-run SHALL abandon the run with no uo_done; rst has priority over all inputs.

Configuration
REQ-027 Macro TERNARY_MAC_SATURATE_EN defined: each channel SHALL emit one byte, accumulator saturated to [-128,127]; DRAIN = out_len cycles.
REQ-028 Macro undefined: each channel SHALL emit two bytes, accumulator[15:8] then [7:0]; DRAIN = 2*out_len cycles.

Verification
REQ-029 SAT on, in_len=2, out_len=1, w(0,0)=+1, w(1,0)=-1, x={10,3} -> single byte 8'h07 with out_valid, uo_done one cycle later.
REQ-030 SAT on, in_len=16, out_len=1, all w=+1, all x=100 -> sum 1600 saturates -> 8'h7F; all w=-1 -> 8'h80.
REQ-031 SAT off, same all-+1/100 run -> bytes 8'h06, 8'h40 (1600), then uo_done.
REQ-032 SAT on, in_len=3, out_len=8, in_valid gaps of 2 cycles between beats, ui_input[7:0]=8'h7F on last beat -> bit ignored, 8 bytes emitted in channel order, weights 2'b10 treated as 0.
REQ-033 ena dropped during DRAIN after 3 bytes -> out_valid=0 next cycle, no uo_done; next run produces correct fresh results.
REQ-034 rst pulsed mid-ACCUM -> all outputs zero next cycle; new run with in_len=1, w=+1, x=-5 -> 8'hFB (SAT on).

Source files
------------

// File: rtl/ternary_mac_out.sv
// Ternary-weight multiply-accumulate with a byte-serial result stream.
// Activations arrive two per beat and are applied to every active output
// channel in parallel. Weights are 2'b01=+1, 2'b11=-1, anything else 0.
// Once all beats are in, the channel sums stream out one byte per cycle,
// followed by a single-cycle uo_done pulse.
//
// Build option: define TERNARY_MAC_SATURATE_EN to emit one byte per channel
// (sum clamped to [-128,127]). Without it, each channel is emitted as two
// bytes, high byte first.
//
// Handshake: in_valid qualifies ui_input and is accepted unconditionally
// while accumulating (there is no ready). out_valid qualifies uo_output.
// The output has no backpressure: once draining starts, a byte is produced
// every cycle.
module ternary_mac_out #(
   parameter int MAX_IN_LEN  = 16,
   parameter int MAX_OUT_LEN = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 ena,
   input  logic [6:0]                           ui_param,
   input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  ui_weights,
   input  logic [15:0]                          ui_input,
   input  logic                                 in_valid,
   output logic [7:0]                           uo_output,
   output logic                                 out_valid,
   output logic                                 uo_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nx;

   logic [3:0]         in_len_m1;
   logic [2:0]         out_len_m1;
   logic [2:0]         beat_cnt;
   logic [3:0]         drain_cnt;
   logic signed [15:0] acc    [MAX_OUT_LEN];
   logic signed [15:0] acc_nx [MAX_OUT_LEN];

   logic signed [7:0]  x_hi;
   logic signed [7:0]  x_lo;
   logic               use_lo;
   logic               last_beat;
   logic               last_drain;
   logic [2:0]         ch_sel;
   logic signed [15:0] sel_acc;
   logic [7:0]         drain_byte;

   // Ternary weight applied to a sign-extended activation.
   function automatic logic signed [15:0] tern(input logic [1:0] w, input logic signed [7:0] x);
      logic signed [15:0] xe;
      xe = {{8{x[7]}}, x};
      case (w)
         2'b01:   tern = xe;
         2'b11:   tern = -xe;
         default: tern = 16'sd0;
      endcase
   endfunction

   assign x_hi      = signed'(ui_input[15:8]);
   assign x_lo      = signed'(ui_input[7:0]);
   // The low activation exists only while its index 2k+1 is below in_len;
   // on the final beat of an odd-length vector it is padding.
   assign use_lo    = ({beat_cnt, 1'b1} <= in_len_m1);
   assign last_beat = (beat_cnt == in_len_m1[3:1]);

`ifdef TERNARY_MAC_SATURATE_EN
   assign ch_sel     = drain_cnt[2:0];
   assign last_drain = (drain_cnt == {1'b0, out_len_m1});
`else
   assign ch_sel     = drain_cnt[3:1];
   assign last_drain = (drain_cnt == {out_len_m1, 1'b1});
`endif

   assign sel_acc = acc[ch_sel];

   // Candidate accumulator values if the current beat is taken.
   always_comb begin
      for (int o = 0; o < MAX_OUT_LEN; o++) begin
         acc_nx[o] = acc[o]
                   + tern(ui_weights[2*(o*MAX_IN_LEN + 2*int'(beat_cnt)) +: 2], x_hi)
                   + (use_lo ? tern(ui_weights[2*(o*MAX_IN_LEN + 2*int'(beat_cnt) + 1) +: 2], x_lo)
                             : 16'sd0);
      end
   end

   // Byte presented for the channel currently being drained.
   always_comb begin
      drain_byte = 8'h00;
`ifdef TERNARY_MAC_SATURATE_EN
      if (sel_acc > 16'sd127)
         drain_byte = 8'h7F;
      else if (sel_acc < -16'sd128)
         drain_byte = 8'h80;
      else
         drain_byte = sel_acc[7:0];
`else
      drain_byte = drain_cnt[0] ? sel_acc[7:0] : sel_acc[15:8];
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic; dropping ena while busy abandons the run.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (ena) state_nx = S_ACCUM;
         S_ACCUM: begin
            if (!ena)
               state_nx = S_IDLE;
            else if (in_valid && last_beat)
               state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if (!ena)
               state_nx = S_IDLE;
            else if (last_drain)
               state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Config latch, accumulators and beat/drain counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_len_m1  <= 4'd0;
         out_len_m1 <= 3'd0;
         beat_cnt   <= 3'd0;
         drain_cnt  <= 4'd0;
         for (int o = 0; o < MAX_OUT_LEN; o++) acc[o] <= 16'sd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ena) begin
                  in_len_m1  <= ui_param[6:3];
                  out_len_m1 <= ui_param[2:0];
                  beat_cnt   <= 3'd0;
                  drain_cnt  <= 4'd0;
                  for (int o = 0; o < MAX_OUT_LEN; o++) acc[o] <= 16'sd0;
               end
            end
            S_ACCUM: begin
               if (ena && in_valid) begin
                  beat_cnt <= beat_cnt + 3'd1;
                  for (int o = 0; o < MAX_OUT_LEN; o++)
                     if (3'(o) <= out_len_m1) acc[o] <= acc_nx[o];
               end
            end
            S_DRAIN: begin
               if (ena) drain_cnt <= drain_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Outputs are a function of state only; silent outside DRAIN.
   always_comb begin
      uo_output = 8'h00;
      out_valid = 1'b0;
      uo_done   = (state == S_DONE);
      if (state == S_DRAIN) begin
         out_valid = 1'b1;
         uo_output = drain_byte;
      end
   end

endmodule
